// File: rtl/prog_sync_counter.sv
// Parametrised synchronous up/down counter with programmable limit, wrap/saturate/one-shot
// terminal modes, a registered terminal-count pulse and a combinational compare flag.
module prog_sync_counter #(
  parameter int unsigned           WIDTH     = 8,
  parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic [WIDTH-1:0] limit,
  input  logic [1:0]       mode,
  input  logic             out_en,
  input  logic [WIDTH-1:0] cmp_val,
  output logic [WIDTH-1:0] count_out,
  output logic             tc,
  output logic             cmp_match,
  output logic             done
);

  localparam logic [1:0] MODE_SAT     = 2'b01;
  localparam logic [1:0] MODE_ONESHOT = 2'b10;

  typedef enum logic [1:0] {
    ST_COUNT = 2'b00,
    ST_SAT   = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] count, count_nxt;
  logic             tc_nxt;
  logic             done_nxt;
  logic             sat_dir, sat_dir_nxt;
  logic             at_term;
  logic             wrap_mode;
  logic [WIDTH-1:0] step_val;

  // Up-count treats anything at or above limit as terminal so a shrunken limit recovers.
  assign at_term   = dir ? (count >= limit) : (count == '0);
  assign wrap_mode = (mode != MODE_SAT) && (mode != MODE_ONESHOT);
  assign step_val  = dir ? (count + WIDTH'(1)) : (count - WIDTH'(1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_COUNT;
      count   <= RESET_VAL;
      tc      <= 1'b0;
      done    <= 1'b0;
      sat_dir <= 1'b0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      tc      <= tc_nxt;
      done    <= done_nxt;
      sat_dir <= sat_dir_nxt;
    end
  end

  // Next-state and next-count logic; load overrides every state
  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    tc_nxt      = 1'b0;
    done_nxt    = done;
    sat_dir_nxt = sat_dir;
    if (load) begin
      count_nxt = load_val;
      state_nxt = ST_COUNT;
      done_nxt  = 1'b0;
    end else begin
      unique case (state)
        ST_COUNT: begin
          if (en) begin
            if (!at_term) begin
              count_nxt = step_val;
            end else begin
              tc_nxt = 1'b1;
              if (mode == MODE_SAT) begin
                state_nxt   = ST_SAT;
                sat_dir_nxt = dir;
              end else if (mode == MODE_ONESHOT) begin
                state_nxt = ST_DONE;
                done_nxt  = 1'b1;
              end else begin
                count_nxt = dir ? '0 : limit;
              end
            end
          end
        end
        ST_SAT: begin
          // Leaving saturation never produces a terminal pulse
          if (wrap_mode) begin
            state_nxt = ST_COUNT;
          end else if (en && (dir != sat_dir)) begin
            count_nxt = step_val;
            state_nxt = ST_COUNT;
          end
        end
        ST_DONE: begin
          state_nxt = ST_DONE;
        end
        default: begin
          state_nxt = ST_COUNT;
        end
      endcase
    end
  end

  assign count_out = out_en ? count : '0;
  assign cmp_match = (count == cmp_val);

endmodule

// File: tb/tb_prog_sync_counter.sv
// Directed bench for prog_sync_counter: expected count/tc/done are queued when a step is
// driven and popped for comparison after the following clock edge.
module tb_prog_sync_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       load;
  logic [7:0] load_val;
  logic       dir;
  logic [7:0] limit;
  logic [1:0] mode;
  logic       out_en;
  logic [7:0] cmp_val;
  logic [7:0] count_out;
  logic       tc;
  logic       cmp_match;
  logic       done;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [7:0] cnt;
    logic       tc;
    logic       done;
  } exp_t;

  exp_t sb[$];

  prog_sync_counter #(.WIDTH(8), .RESET_VAL(8'd0)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
    .dir(dir), .limit(limit), .mode(mode), .out_en(out_en), .cmp_val(cmp_val),
    .count_out(count_out), .tc(tc), .cmp_match(cmp_match), .done(done)
  );

  always #5 clk = ~clk;

  task automatic push(input int c, input bit t, input bit d);
    exp_t e;
    e.cnt  = 8'(c);
    e.tc   = t;
    e.done = d;
    sb.push_back(e);
  endtask

  task automatic check_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: scoreboard empty, nothing expected", tag);
    end else begin
      e = sb.pop_front();
      checks++;
      assert (count_out === e.cnt) else begin
        errors++;
        $error("FAIL %s count_out: got %0d want %0d", tag, count_out, e.cnt);
      end
      checks++;
      assert (tc === e.tc) else begin
        errors++;
        $error("FAIL %s tc: got %0b want %0b", tag, tc, e.tc);
      end
      checks++;
      assert (done === e.done) else begin
        errors++;
        $error("FAIL %s done: got %0b want %0b", tag, done, e.done);
      end
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    #1;
    check_front(tag);
  endtask

  task automatic check_cmp(input string tag, input bit want);
    checks++;
    assert (cmp_match === want) else begin
      errors++;
      $error("FAIL %s cmp_match: got %0b want %0b", tag, cmp_match, want);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; load = 1'b0; load_val = 8'd0; dir = 1'b1;
    limit = 8'd255; mode = 2'b00; out_en = 1'b1; cmp_val = 8'd0;
    push(0, 0, 0); tick("reset");
    check_cmp("reset_cmp", 1'b1);

    // Full 8-bit wrap: tc only after 255 -> 0
    rst = 1'b0; en = 1'b1;
    for (int i = 0; i <= 256; i++) begin
      push((i + 1) % 256, i == 255, 0);
      tick("wrap256");
    end

    // Load beats enable, no tc on load
    en = 1'b0; load = 1'b1; load_val = 8'd9;
    push(9, 0, 0); tick("load9");
    en = 1'b1; load_val = 8'd5;
    push(5, 0, 0); tick("load_wins");
    load = 1'b0;
    push(6, 0, 0); tick("after_load");
    push(7, 0, 0); tick("after_load");

    // Down wrap at limit 9
    en = 1'b0; dir = 1'b0; limit = 8'd9; load = 1'b1; load_val = 8'd2;
    push(2, 0, 0); tick("dn_load");
    load = 1'b0; en = 1'b1;
    push(1, 0, 0); tick("dn_wrap");
    push(0, 0, 0); tick("dn_wrap");
    push(9, 1, 0); tick("dn_wrap");
    push(8, 0, 0); tick("dn_wrap");

    // Up saturate at 10, single tc, then reverse out of saturation
    en = 1'b0; dir = 1'b1; mode = 2'b01; limit = 8'd10; load = 1'b1; load_val = 8'd8;
    push(8, 0, 0); tick("sat_load");
    load = 1'b0; en = 1'b1;
    push(9, 0, 0); tick("sat");
    push(10, 0, 0); tick("sat");
    push(10, 1, 0); tick("sat");
    push(10, 0, 0); tick("sat");
    push(10, 0, 0); tick("sat");
    push(10, 0, 0); tick("sat");
    dir = 1'b0;
    push(9, 0, 0); tick("sat_rev");

    // Down one-shot: freezes at 0 until load
    en = 1'b0; mode = 2'b10; load = 1'b1; load_val = 8'd3;
    push(3, 0, 0); tick("os_load");
    load = 1'b0; en = 1'b1;
    push(2, 0, 0); tick("oneshot");
    push(1, 0, 0); tick("oneshot");
    push(0, 0, 0); tick("oneshot");
    push(0, 1, 1); tick("oneshot_term");
    push(0, 0, 1); tick("oneshot_hold");
    dir = 1'b1; mode = 2'b00;
    push(0, 0, 1); tick("oneshot_frozen");
    en = 1'b0; load = 1'b1; load_val = 8'd7;
    push(7, 0, 0); tick("oneshot_reload");
    load = 1'b0;

    // Leaving saturation by switching to wrap: wrap applies on the following step
    dir = 1'b1; mode = 2'b01; limit = 8'd5; load = 1'b1; load_val = 8'd5;
    push(5, 0, 0); tick("satwrap_load");
    load = 1'b0; en = 1'b1;
    push(5, 1, 0); tick("satwrap_sat");
    mode = 2'b00;
    push(5, 0, 0); tick("satwrap_exit");
    push(0, 1, 0); tick("satwrap_wrap");

    // load_val above limit: up-count is terminal at once
    en = 1'b0; load = 1'b1; load_val = 8'd9;
    push(9, 0, 0); tick("over_load");
    load = 1'b0; en = 1'b1;
    push(0, 1, 0); tick("over_term");

    // Down from above limit decrements normally
    en = 1'b0; dir = 1'b0; load = 1'b1; load_val = 8'd9;
    push(9, 0, 0); tick("over_dn_load");
    load = 1'b0; en = 1'b1;
    push(8, 0, 0); tick("over_dn");
    push(7, 0, 0); tick("over_dn");

    // limit 0 up wrap: holds 0, tc every enabled cycle
    en = 1'b0; dir = 1'b1; limit = 8'd0; load = 1'b1; load_val = 8'd0;
    push(0, 0, 0); tick("lim0_load");
    load = 1'b0; en = 1'b1;
    push(0, 1, 0); tick("lim0");
    push(0, 1, 0); tick("lim0");

    // out_en gating while counting continues, then compare
    en = 1'b0; limit = 8'd255; load = 1'b1; load_val = 8'd20;
    push(20, 0, 0); tick("gate_load");
    load = 1'b0; en = 1'b1; out_en = 1'b0; cmp_val = 8'd24;
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 0); tick("gated");
      check_cmp("gated_cmp", i == 3);
    end
    en = 1'b0; out_en = 1'b1;
    #1;
    push(24, 0, 0); check_front("ungated");
    check_cmp("cmp24", 1'b1);

    // Reset at the terminal step drops the pending tc
    limit = 8'd25; en = 1'b1;
    push(25, 0, 0); tick("pre_rst");
    check_cmp("cmp25", 1'b0);
    rst = 1'b1;
    push(0, 0, 0); tick("mid_rst");
    cmp_val = 8'd0;
    #1;
    check_cmp("rst_cmp", 1'b1);
    rst = 1'b0; en = 1'b0;

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: got %0d entries want 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
